// File: rtl/divider_pkg.sv
// Shared definitions for the sequential divider.
//   state_e      : FSM state encoding (IDLE, RUN, DONE)
//   count_width  : width of the step counter for a given operand width
package divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // The counter must hold 0..WORD_LENGTH without wrapping.
  function automatic int count_width(input int word_length);
    return $clog2(word_length + 1);
  endfunction

endpackage

// File: rtl/div_step_counter.sv
// Step counter for the sequential divider.
//   clk        : clock, rising edge
//   reset      : asynchronous active-high clear
//   clear      : synchronous clear (new division accepted)
//   enable     : count one step
//   last_step  : combinational, high while the count equals WORD_LENGTH-1
module div_step_counter #(
  parameter int WORD_LENGTH = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last_step
);

  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign last_step = (count_q == COUNT_WIDTH'(WORD_LENGTH - 1));

endmodule

// File: rtl/sequential_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
//   clk, reset            : clock and asynchronous active-high reset
//   start                 : request, accepted only while ready
//   dividend, divisor     : operands, captured on an accepted start
//   ready                 : high in IDLE
//   done                  : one-cycle pulse when results are valid
//   quotient, remainder   : registered results, held between divisions
//   div_by_zero           : registered flag for a zero divisor
module sequential_divider
  import divider_pkg::*;
#(
  parameter int WORD_LENGTH = 4,
  parameter int COUNT_WIDTH = count_width(WORD_LENGTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] dividend,
  input  logic [WORD_LENGTH-1:0] divisor,
  output logic                   ready,
  output logic                   done,
  output logic [WORD_LENGTH-1:0] quotient,
  output logic [WORD_LENGTH-1:0] remainder,
  output logic                   div_by_zero
);

  state_e                 state_q, state_d;
  // q_q starts as the dividend; its MSB feeds the remainder each step while
  // quotient bits shift in from the bottom.
  logic [WORD_LENGTH-1:0] q_q, q_d;
  logic [WORD_LENGTH-1:0] rem_q, rem_d;
  logic [WORD_LENGTH-1:0] dvs_q, dvs_d;
  logic [WORD_LENGTH-1:0] quot_q, quot_d;
  logic [WORD_LENGTH-1:0] remo_q, remo_d;
  logic                   dbz_q, dbz_d;

  logic                   cnt_clear;
  logic                   cnt_enable;
  logic                   last_step;

  logic [WORD_LENGTH:0]   partial;
  logic                   step_ge;
  logic [WORD_LENGTH-1:0] step_rem;
  logic [WORD_LENGTH-1:0] step_q;

  div_step_counter #(
    .WORD_LENGTH (WORD_LENGTH),
    .COUNT_WIDTH (COUNT_WIDTH)
  ) u_step_counter (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear),
    .enable    (cnt_enable),
    .last_step (last_step)
  );

  // One extra bit so all-ones operands compare correctly. When the subtract
  // happens the result is below the divisor, so truncation to WORD_LENGTH
  // bits is exact.
  always_comb begin
    partial  = {rem_q, q_q[WORD_LENGTH-1]};
    step_ge  = (partial >= {1'b0, dvs_q});
    step_rem = step_ge ? (partial[WORD_LENGTH-1:0] - dvs_q) : partial[WORD_LENGTH-1:0];
    step_q   = {q_q[WORD_LENGTH-2:0], step_ge};
  end

  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    rem_d      = rem_q;
    dvs_d      = dvs_q;
    quot_d     = quot_q;
    remo_d     = remo_q;
    dbz_d      = dbz_q;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          q_d       = dividend;
          dvs_d     = divisor;
          rem_d     = '0;
          dbz_d     = 1'b0;
          cnt_clear = 1'b1;
          if (divisor == '0) begin
            quot_d  = '1;
            remo_d  = dividend;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        cnt_enable = 1'b1;
        q_d        = step_q;
        rem_d      = step_rem;
        if (last_step) begin
          quot_d  = step_q;
          remo_d  = step_rem;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quotient    = quot_q;
  assign remainder   = remo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_sequential_divider.sv
module tb_sequential_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         ready;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int failures = 0;

  sequential_divider #(.WORD_LENGTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .ready       (ready),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic, with the zero-divisor convention.
  function automatic logic [W-1:0] ref_q(input int a, input int b);
    if (b == 0) return {W{1'b1}};
    return W'(a / b);
  endfunction

  function automatic logic [W-1:0] ref_r(input int a, input int b);
    if (b == 0) return W'(a);
    return W'(a % b);
  endfunction

  // Cycles sampled (at negedges) after the start edge until done is seen.
  function automatic int ref_lat(input int b);
    return (b == 0) ? 1 : W + 1;
  endfunction

  // Launches one division and waits for done. lat = -1 if done never came.
  task automatic run_div(input int a, input int b, output int lat,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int ready_hi);
    bit found;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat = -1; ready_hi = 0; found = 0;
    q = 'x; r = 'x; z = 1'bx;
    for (int i = 1; i <= 20 && !found; i++) begin
      @(negedge clk);
      if (ready) ready_hi++;
      if (done) begin
        found = 1;
        lat = i;
        q = quotient;
        r = remainder;
        z = div_by_zero;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b done=%b q=%0d r=%0d dbz=%b, want ready=1 done=0 q=0 r=0 dbz=0",
               ready, done, quotient, remainder, div_by_zero);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: got ready=%b done=%b, want ready=1 done=0", ready, done);
    end
  endtask

  task automatic test_directed();
    int a_tab [5] = '{13, 15, 15, 7, 9};
    int b_tab [5] = '{3, 1, 15, 9, 0};
    int lat, rh;
    logic [W-1:0] q, r;
    logic z;
    for (int k = 0; k < 5; k++) begin
      run_div(a_tab[k], b_tab[k], lat, q, r, z, rh);
      checks++;
      if (lat !== ref_lat(b_tab[k])) begin
        failures++;
        $display("FAIL directed_latency %0d/%0d: got %0d cycles, want %0d", a_tab[k], b_tab[k], lat, ref_lat(b_tab[k]));
      end
      checks++;
      if (q !== ref_q(a_tab[k], b_tab[k]) || r !== ref_r(a_tab[k], b_tab[k]) || z !== (b_tab[k] == 0)) begin
        failures++;
        $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%0d",
                 a_tab[k], b_tab[k], q, r, z, ref_q(a_tab[k], b_tab[k]), ref_r(a_tab[k], b_tab[k]), b_tab[k] == 0);
      end
      checks++;
      if (rh !== 0) begin
        failures++;
        $display("FAIL directed_ready_busy %0d/%0d: ready high in %0d busy cycles, want 0", a_tab[k], b_tab[k], rh);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ready !== 1'b1) begin
        failures++;
        $display("FAIL directed_done_pulse %0d/%0d: got done=%b ready=%b after pulse, want done=0 ready=1",
                 a_tab[k], b_tab[k], done, ready);
      end
    end
  endtask

  task automatic test_dbz_clear();
    int lat, rh;
    logic [W-1:0] q, r;
    logic z;
    run_div(9, 0, lat, q, r, z, rh);
    run_div(8, 2, lat, q, r, z, rh);
    checks++;
    if (z !== 1'b0 || q !== 4'd4 || r !== 4'd0) begin
      failures++;
      $display("FAIL dbz_clear: got dbz=%b q=%0d r=%0d, want dbz=0 q=4 r=0", z, q, r);
    end
  endtask

  task automatic test_ignore_start();
    int pulses = 0;
    logic [W-1:0] q = 'x, r = 'x;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    dividend = 4'd2; divisor = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        q = quotient;
        r = remainder;
      end
    end
    checks++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL ignore_start_pulses: got %0d done pulses, want 1", pulses);
    end
    checks++;
    if (q !== 4'd4 || r !== 4'd1) begin
      failures++;
      $display("FAIL ignore_start_result: got q=%0d r=%0d, want q=4 r=1", q, r);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses = 0;
    int lat, rh;
    logic [W-1:0] q, r;
    logic z;
    @(negedge clk);
    dividend = 4'd13; divisor = 4'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, done, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, {W{1'b0}}, {W{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL mid_run_reset_outputs: got ready=%b done=%b q=%0d r=%0d dbz=%b, want 1 0 0 0 0",
               ready, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    checks++;
    if (pulses !== 0 || ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_run_reset_no_done: got %0d pulses ready=%b, want 0 pulses ready=1", pulses, ready);
    end
    run_div(6, 4, lat, q, r, z, rh);
    checks++;
    if (q !== 4'd1 || r !== 4'd2 || lat !== W + 1) begin
      failures++;
      $display("FAIL after_reset_div: got q=%0d r=%0d lat=%0d, want q=1 r=2 lat=%0d", q, r, lat, W + 1);
    end
  endtask

  task automatic test_random();
    int a, b, lat, rh;
    logic [W-1:0] q, r;
    logic z;
    for (int k = 0; k < 40; k++) begin
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 15);
      run_div(a, b, lat, q, r, z, rh);
      checks++;
      if (lat !== ref_lat(b) || q !== ref_q(a, b) || r !== ref_r(a, b) || z !== (b == 0) || rh !== 0) begin
        failures++;
        $display("FAIL random %0d/%0d: got lat=%0d q=%0d r=%0d dbz=%b ready_hi=%0d, want lat=%0d q=%0d r=%0d dbz=%0d ready_hi=0",
                 a, b, lat, q, r, z, rh, ref_lat(b), ref_q(a, b), ref_r(a, b), b == 0);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, rh;
    logic [W-1:0] q, r;
    logic z;
    run_div(15, 15, lat, q, r, z, rh);
    run_div(14, 15, lat, q, r, z, rh);
    checks++;
    if (q !== 4'd0 || r !== 4'd14 || lat !== W + 1) begin
      failures++;
      $display("FAIL back_to_back: got q=%0d r=%0d lat=%0d, want q=0 r=14 lat=%0d", q, r, lat, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_dbz_clear();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
